regfile_wb_sched: RTL



---
 rtl/regfile_wb_sched_if.sv | 42 ++++
 rtl/regfile_wb_sched.sv | 132 +++++++++++++
 2 files changed

// File: rtl/regfile_wb_sched_if.sv
// Bundle of slot results, long-latency handshake and register-file write ports
// seen by the writeback scheduler.
interface regfile_wb_sched_if #(
  parameter int LQ_DEPTH = 4
);
  localparam int CW = $clog2(LQ_DEPTH) + 1;

  logic          r_valid;
  logic [2:0]    r_dest;
  logic [31:0]   r_data;
  logic          s_valid;
  logic [2:0]    s_dest;
  logic [31:0]   s_data;
  logic          l_valid;
  logic [2:0]    l_dest;
  logic [31:0]   l_data;
  logic          l_ready;
  logic          RregWrite;
  logic [2:0]    Rd;
  logic [31:0]   RwriteData;
  logic          SregWrite;
  logic [2:0]    Sd;
  logic [31:0]   SwriteData;
  logic [7:0]    busy_mask;
  logic [CW-1:0] lq_count;
  logic          rs_conflict;
  logic          lq_kill;

  modport master (
    output r_valid, r_dest, r_data, s_valid, s_dest, s_data,
           l_valid, l_dest, l_data,
    input  l_ready, RregWrite, Rd, RwriteData, SregWrite, Sd, SwriteData,
           busy_mask, lq_count, rs_conflict, lq_kill
  );

  modport slave (
    input  r_valid, r_dest, r_data, s_valid, s_dest, s_data,
           l_valid, l_dest, l_data,
    output l_ready, RregWrite, Rd, RwriteData, SregWrite, Sd, SwriteData,
           busy_mask, lq_count, rs_conflict, lq_kill
  );
endinterface

// File: rtl/regfile_wb_sched.sv
// Dual-port register-file writeback scheduler: R/S pass-through plus a queue of
// long-latency results drained into idle ports, with WAW kills and a busy mask.
module regfile_wb_sched #(
  parameter int LQ_DEPTH = 4
) (
  input logic               clk,
  input logic               reset,
  regfile_wb_sched_if.slave wb
);
  localparam int PW = $clog2(LQ_DEPTH);
  localparam int CW = PW + 1;

  logic [2:0]          qDest [LQ_DEPTH];
  logic [31:0]         qData [LQ_DEPTH];
  logic [LQ_DEPTH-1:0] qValid;
  logic [LQ_DEPTH-1:0] qValidNext;
  logic [LQ_DEPTH-1:0] entryHit;
  logic [PW-1:0]       rdPtr;
  logic [PW-1:0]       wrPtr;
  logic [CW-1:0]       count;
  logic [7:0]          busyMask;
  logic [7:0]          busyNext;

  logic rLive, sLive, rsConflict, sPortUsed;
  logic full, accept, inKill, enqueue;
  logic headPresent, headDead, drainS, drainR, pop;

  assign rLive      = wb.r_valid && (wb.r_dest != 3'd0);
  assign sLive      = wb.s_valid && (wb.s_dest != 3'd0);
  assign rsConflict = rLive && sLive && (wb.r_dest == wb.s_dest);
  assign sPortUsed  = sLive && !rsConflict;

  assign full    = (count == CW'(LQ_DEPTH));
  assign accept  = wb.l_valid && !full && !reset;
  assign inKill  = (rLive && (wb.l_dest == wb.r_dest)) ||
                   (sLive && (wb.l_dest == wb.s_dest));
  assign enqueue = accept && (wb.l_dest != 3'd0) && !inKill;

  // Queued results are older than this cycle's R/S results, so matches die.
  always_comb begin
    entryHit = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      entryHit[i] = qValid[i] &&
                    ((rLive && (qDest[i] == wb.r_dest)) ||
                     (sLive && (qDest[i] == wb.s_dest)));
    end
  end

  assign headPresent = (count != '0) && !reset;
  assign headDead    = !qValid[rdPtr] || entryHit[rdPtr];
  assign drainS      = headPresent && !headDead && !sPortUsed;
  assign drainR      = headPresent && !headDead && sPortUsed && !rLive;
  assign pop         = (headPresent && headDead) || drainS || drainR;

  always_comb begin
    qValidNext = qValid & ~entryHit;
    if (pop)
      qValidNext[rdPtr] = 1'b0;
    if (enqueue)
      qValidNext[wrPtr] = 1'b1;
    busyNext = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (qValidNext[i]) begin
        if (enqueue && (wrPtr == PW'(i)))
          busyNext[wb.l_dest] = 1'b1;
        else
          busyNext[qDest[i]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      qValid   <= '0;
      busyMask <= '0;
    end else begin
      qValid   <= qValidNext;
      busyMask <= busyNext;
      if (pop)
        rdPtr <= rdPtr + 1'b1;
      if (enqueue)
        wrPtr <= wrPtr + 1'b1;
      count <= count + CW'(enqueue) - CW'(pop);
    end
  end

  // Payload storage carries no reset; validity alone decides what is live.
  always_ff @(posedge clk) begin
    if (enqueue) begin
      qDest[wrPtr] <= wb.l_dest;
      qData[wrPtr] <= wb.l_data;
    end
  end

  always_comb begin
    wb.RregWrite  = 1'b0;
    wb.Rd         = '0;
    wb.RwriteData = '0;
    wb.SregWrite  = 1'b0;
    wb.Sd         = '0;
    wb.SwriteData = '0;
    if (!reset) begin
      if (rLive) begin
        wb.RregWrite  = 1'b1;
        wb.Rd         = wb.r_dest;
        wb.RwriteData = wb.r_data;
      end else if (drainR) begin
        wb.RregWrite  = 1'b1;
        wb.Rd         = qDest[rdPtr];
        wb.RwriteData = qData[rdPtr];
      end
      if (sPortUsed) begin
        wb.SregWrite  = 1'b1;
        wb.Sd         = wb.s_dest;
        wb.SwriteData = wb.s_data;
      end else if (drainS) begin
        wb.SregWrite  = 1'b1;
        wb.Sd         = qDest[rdPtr];
        wb.SwriteData = qData[rdPtr];
      end
    end
  end

  assign wb.l_ready     = !full && !reset;
  assign wb.rs_conflict = rsConflict && !reset;
  assign wb.lq_kill     = !reset && ((|entryHit) || (accept && inKill));
  assign wb.busy_mask   = busyMask;
  assign wb.lq_count    = count;
endmodule
